i2c_slave_regif: RTL and testbench

- I2C target (slave) responder, the other end of the mi2c master controller protocol.
- Decodes START, device address, 8- or 16-bit register address, and write data from SCL/SDA.
- Presents a simple synchronous register-bus interface: write strobe, read strobe, one-cycle read latency.
- Used as an on-chip register target in loopback benches against the master, and as a board-level slave.

---
 rtl/i2c_pkg.sv | 45 ++++
 rtl/i2c_slave_filt.sv | 53 +++++
 rtl/i2c_slave_regif.sv | 173 +++++++++++++++++
 tb/tb_i2c_slave_regif.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared constants for the I2C register-target slice:
// one-hot FSM encoding, bus levels, address-length codes, pointer helper.
package i2c_pkg;

  localparam int S_IDLE      = 0;
  localparam int S_DEV       = 1;
  localparam int S_DEV_ACK   = 2;
  localparam int S_ADDR_H    = 3;
  localparam int S_ADDR_L    = 4;
  localparam int S_ADDR_ACK  = 5;
  localparam int S_WDATA     = 6;
  localparam int S_WDATA_ACK = 7;
  localparam int S_RDATA     = 8;
  localparam int S_MACK      = 9;
  localparam int S_IGNORE    = 10;

  typedef enum logic [10:0] {
    IDLE      = 11'b1 << S_IDLE,
    DEV       = 11'b1 << S_DEV,
    DEV_ACK   = 11'b1 << S_DEV_ACK,
    ADDR_H    = 11'b1 << S_ADDR_H,
    ADDR_L    = 11'b1 << S_ADDR_L,
    ADDR_ACK  = 11'b1 << S_ADDR_ACK,
    WDATA     = 11'b1 << S_WDATA,
    WDATA_ACK = 11'b1 << S_WDATA_ACK,
    RDATA     = 11'b1 << S_RDATA,
    MACK      = 11'b1 << S_MACK,
    IGNORE    = 11'b1 << S_IGNORE
  } state_t;

  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;
  localparam logic ADDR8  = 1'b0;
  localparam logic ADDR16 = 1'b1;

  // 8-bit mode wraps inside the low byte and keeps [15:8] at zero
  function automatic logic [15:0] ptr_inc(
    input logic [15:0] a,
    input logic        wide
  );
    if (wide == ADDR16) return a + 16'd1;
    return {8'h00, a[7:0] + 8'd1};
  endfunction

endpackage

// File: rtl/i2c_slave_filt.sv
// SCL/SDA conditioning: 2-FF sync, FILT_LEN glitch filter, edge/START/STOP.
// Ports: clk_i, rst_n, scl_i, sda_i -> sda_o, scl_rise_o, scl_fall_o, start_o, stop_o.
module i2c_slave_filt #(
  parameter int FILT_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  localparam int CW = $clog2(FILT_LEN + 1);

  // bit 0 = SCL, bit 1 = SDA; idle bus is high
  logic [1:0]    s1, s2, flt, hist;
  logic [CW-1:0] cnt [2];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '1;
      s2   <= '1;
      flt  <= '1;
      hist <= '1;
      cnt  <= '{default: '0};
    end else begin
      s1   <= {sda_i, scl_i};
      s2   <= s1;
      hist <= flt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == flt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILT_LEN - 1)) begin
          flt[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign sda_o      = flt[1];
  assign scl_rise_o = flt[0] & ~hist[0];
  assign scl_fall_o = ~flt[0] & hist[0];
  assign start_o    = flt[0] & hist[0] & hist[1] & ~flt[1];
  assign stop_o     = flt[0] & hist[0] & ~hist[1] & flt[1];

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C target that turns bus transfers into register-bus strobes.
// Ports: scl_i/sda_i/sda_oe_o bus, dev_addr_i, addr_len_i, reg_* bus, busy_o, stop_o.
module i2c_slave_regif
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = 3,
  parameter int SYS_CLK  = 50_000_000,
  parameter int I2C_CLK  = 400_000
) (
  input  logic        rst_n,
  input  logic        clk_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  input  logic [6:0]  dev_addr_i,
  input  logic        addr_len_i,
  output logic [15:0] reg_addr_o,
  output logic [7:0]  reg_wdata_o,
  output logic        reg_wren_o,
  output logic        reg_rden_o,
  input  logic [7:0]  reg_rdata_i,
  output logic        busy_o,
  output logic        stop_o
);

  if (SYS_CLK / I2C_CLK < 16) begin : g_clk_chk
    $error("i2c_slave_regif: SYS_CLK/I2C_CLK must be >= 16");
  end

  logic sda_f, scl_rise, scl_fall, start_det, stop_det;

  i2c_slave_filt #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_f),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  state_t     state;
  logic [3:0] bcnt;
  logic [7:0] shreg;
  logic       a16, rw, hi_done, rd_lat;

  logic [7:0] rx_byte;
  logic       last_bit;
  assign rx_byte  = {shreg[6:0], sda_f};
  assign last_bit = (bcnt == 4'd7);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bcnt        <= '0;
      shreg       <= '0;
      a16         <= ADDR8;
      rw          <= 1'b0;
      hi_done     <= 1'b0;
      rd_lat      <= 1'b0;
      sda_oe_o    <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_wren_o  <= 1'b0;
      reg_rden_o  <= 1'b0;
      busy_o      <= 1'b0;
      stop_o      <= 1'b0;
    end else begin
      reg_wren_o <= 1'b0;
      reg_rden_o <= 1'b0;
      stop_o     <= 1'b0;
      rd_lat     <= reg_rden_o;
      if (rd_lat) shreg <= reg_rdata_i;
      // pointer moves only after the write strobe has been seen
      if (reg_wren_o) reg_addr_o <= ptr_inc(reg_addr_o, a16);

      if (start_det) begin
        state    <= DEV;
        bcnt     <= '0;
        busy_o   <= 1'b1;
        a16      <= addr_len_i;
        sda_oe_o <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        sda_oe_o <= 1'b0;
        stop_o   <= 1'b1;
        busy_o   <= 1'b0;
      end else begin
        unique case (1'b1)
          state[S_DEV]: if (scl_rise) begin
            shreg <= rx_byte;
            bcnt  <= last_bit ? 4'd0 : bcnt + 4'd1;
            if (last_bit) begin
              rw <= rx_byte[0];
              if (rx_byte[7:1] == dev_addr_i) begin
                state      <= DEV_ACK;
                reg_rden_o <= rx_byte[0];
              end else begin
                state <= IGNORE;
              end
            end
          end
          state[S_ADDR_H], state[S_ADDR_L], state[S_WDATA]: if (scl_rise) begin
            shreg <= rx_byte;
            bcnt  <= last_bit ? 4'd0 : bcnt + 4'd1;
            if (last_bit) begin
              if (state[S_WDATA]) begin
                reg_wdata_o <= rx_byte;
                reg_wren_o  <= 1'b1;
                state       <= WDATA_ACK;
              end else if (state[S_ADDR_H]) begin
                reg_addr_o[15:8] <= rx_byte;
                hi_done          <= 1'b1;
                state            <= ADDR_ACK;
              end else begin
                reg_addr_o <= {(a16 == ADDR16) ? reg_addr_o[15:8] : 8'h00,
                               rx_byte};
                hi_done    <= 1'b0;
                state      <= ADDR_ACK;
              end
            end
          end
          // first fall pulls SDA low, second fall ends the ACK slot
          state[S_DEV_ACK], state[S_ADDR_ACK], state[S_WDATA_ACK]: if (scl_fall) begin
            if (!sda_oe_o) begin
              sda_oe_o <= 1'b1;
            end else begin
              sda_oe_o <= 1'b0;
              bcnt     <= '0;
              if (state[S_DEV_ACK] && rw) begin
                sda_oe_o <= ~shreg[7];
                shreg    <= {shreg[6:0], 1'b0};
                state    <= RDATA;
              end else if (state[S_DEV_ACK]) begin
                state <= (a16 == ADDR16) ? ADDR_H : ADDR_L;
              end else if (state[S_ADDR_ACK]) begin
                state <= hi_done ? ADDR_L : WDATA;
              end else begin
                state <= WDATA;
              end
            end
          end
          state[S_RDATA]: begin
            if (scl_rise) bcnt <= bcnt + 4'd1;
            if (scl_fall) begin
              if (bcnt == 4'd8) begin
                sda_oe_o <= 1'b0;
                bcnt     <= '0;
                state    <= MACK;
              end else begin
                sda_oe_o <= ~shreg[7];
                shreg    <= {shreg[6:0], 1'b0};
              end
            end
          end
          state[S_MACK]: if (scl_rise) begin
            if (sda_f == ACK) begin
              reg_addr_o <= ptr_inc(reg_addr_o, a16);
              reg_rden_o <= 1'b1;
              state      <= RDATA;
            end else begin
              state <= IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Directed bench for i2c_slave_regif: bit-banged master, register model.
// Ports: drives scl/sda/dev_addr/addr_len/reg_rdata, observes all outputs.
module tb_i2c_slave_regif;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_oe;
  logic [6:0]  dev_addr = 7'h50;
  logic        addr_len = 1'b0;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_wren, reg_rden;
  logic [7:0]  reg_rdata = 8'h00;
  logic        busy, stop;
  wire         sda_line = sda_m & ~sda_oe;

  int checks = 0;
  int failures = 0;

  int wren_cnt = 0;
  int rden_cnt = 0;
  int stop_cnt = 0;
  int oe_cnt = 0;
  logic [15:0] wr_a [32];
  logic [7:0]  wr_d [32];

  always #5 clk = ~clk;

  i2c_slave_regif dut (
    .rst_n       (rst_n),
    .clk_i       (clk),
    .scl_i       (scl_m),
    .sda_i       (sda_line),
    .sda_oe_o    (sda_oe),
    .dev_addr_i  (dev_addr),
    .addr_len_i  (addr_len),
    .reg_addr_o  (reg_addr),
    .reg_wdata_o (reg_wdata),
    .reg_wren_o  (reg_wren),
    .reg_rden_o  (reg_rden),
    .reg_rdata_i (reg_rdata),
    .busy_o      (busy),
    .stop_o      (stop)
  );

  // register model: one-cycle read latency, data = 0x40 + addr
  always @(posedge clk) begin
    if (reg_rden) begin
      reg_rdata <= 8'h40 + reg_addr[7:0];
      rden_cnt  <= rden_cnt + 1;
    end
    if (reg_wren) begin
      wr_a[wren_cnt[4:0]] <= reg_addr;
      wr_d[wren_cnt[4:0]] <= reg_wdata;
      wren_cnt <= wren_cnt + 1;
    end
    if (stop) stop_cnt <= stop_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    sda_m = b; wq();
    scl_m = 1'b1; wq();
    r = sda_line; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
    i2c_bit(1'b1, r);
    acked = ~r;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, r);
      d[i] = r;
    end
    i2c_bit(mack ? 1'b0 : 1'b1, r);
  endtask

  initial begin
    logic       a;
    logic       r1, r2;
    logic [7:0] d;
    int         w0, rd0, s0, o0, acks;

    repeat (3) @(negedge clk);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_wren", reg_wren, 0);
    chk("rst_rden", reg_rden, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stop", stop, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8-bit write
    w0 = wren_cnt; s0 = stop_cnt;
    i2c_start();
    wr_byte(8'hA0, a); chk("w8_ack_dev", a, 1);
    chk("w8_busy", busy, 1);
    wr_byte(8'h12, a); chk("w8_ack_addr", a, 1);
    wr_byte(8'h5A, a); chk("w8_ack_data", a, 1);
    i2c_stop();
    chk("w8_nwr", wren_cnt - w0, 1);
    chk("w8_wr_addr", wr_a[w0[4:0]], 16'h0012);
    chk("w8_wr_data", wr_d[w0[4:0]], 8'h5A);
    chk("w8_stop", stop_cnt - s0, 1);
    chk("w8_ptr", reg_addr, 16'h0013);
    chk("w8_idle", busy, 0);

    // 16-bit write, three bytes across a page
    addr_len = 1'b1;
    w0 = wren_cnt; acks = 0;
    i2c_start();
    wr_byte(8'hA0, a); acks += int'(a);
    wr_byte(8'h01, a); acks += int'(a);
    wr_byte(8'hFE, a); acks += int'(a);
    wr_byte(8'hD0, a); acks += int'(a);
    wr_byte(8'hD1, a); acks += int'(a);
    wr_byte(8'hD2, a); acks += int'(a);
    i2c_stop();
    addr_len = 1'b0;
    chk("w16_acks", acks, 6);
    chk("w16_nwr", wren_cnt - w0, 3);
    chk("w16_a0", wr_a[w0[4:0]], 16'h01FE);
    chk("w16_d0", wr_d[w0[4:0]], 8'hD0);
    chk("w16_a1", wr_a[5'(w0 + 1)], 16'h01FF);
    chk("w16_d1", wr_d[5'(w0 + 1)], 8'hD1);
    chk("w16_a2", wr_a[5'(w0 + 2)], 16'h0200);
    chk("w16_d2", wr_d[5'(w0 + 2)], 8'hD2);
    chk("w16_ptr", reg_addr, 16'h0201);

    // random read with repeated START
    w0 = wren_cnt; rd0 = rden_cnt;
    i2c_start();
    wr_byte(8'hA0, a); chk("rd_ack_dev", a, 1);
    wr_byte(8'h40, a); chk("rd_ack_addr", a, 1);
    i2c_start();
    wr_byte(8'hA1, a); chk("rd_ack_rdev", a, 1);
    rd_byte(1'b1, d); chk("rd_b0", d, 8'h80);
    rd_byte(1'b1, d); chk("rd_b1", d, 8'h81);
    rd_byte(1'b0, d); chk("rd_b2", d, 8'h82);
    chk("rd_release", sda_oe, 0);
    i2c_stop();
    chk("rd_nrden", rden_cnt - rd0, 3);
    chk("rd_nwr", wren_cnt - w0, 0);

    // address mismatch
    w0 = wren_cnt; rd0 = rden_cnt; o0 = oe_cnt; s0 = stop_cnt;
    i2c_start();
    wr_byte(8'hA2, a); chk("mm_nack_dev", a, 0);
    wr_byte(8'h33, a); chk("mm_nack_data", a, 0);
    chk("mm_busy", busy, 1);
    i2c_stop();
    chk("mm_idle", busy, 0);
    chk("mm_oe", oe_cnt - o0, 0);
    chk("mm_nwr", wren_cnt - w0, 0);
    chk("mm_nrd", rden_cnt - rd0, 0);
    chk("mm_stop", stop_cnt - s0, 1);

    // 8-bit pointer wrap
    w0 = wren_cnt;
    i2c_start();
    wr_byte(8'hA0, a);
    wr_byte(8'hFF, a);
    wr_byte(8'h11, a);
    wr_byte(8'h22, a);
    i2c_stop();
    chk("wrap_nwr", wren_cnt - w0, 2);
    chk("wrap_a0", wr_a[w0[4:0]], 16'h00FF);
    chk("wrap_d0", wr_d[w0[4:0]], 8'h11);
    chk("wrap_a1", wr_a[5'(w0 + 1)], 16'h0000);
    chk("wrap_d1", wr_d[5'(w0 + 1)], 8'h22);
    chk("wrap_ptr", reg_addr, 16'h0001);

    // STOP after half a data byte
    w0 = wren_cnt; s0 = stop_cnt;
    i2c_start();
    wr_byte(8'hA0, a);
    wr_byte(8'h05, a);
    i2c_bit(1'b1, r1);
    i2c_bit(1'b0, r1);
    i2c_bit(1'b1, r1);
    i2c_bit(1'b0, r1);
    i2c_stop();
    chk("part_nwr", wren_cnt - w0, 0);
    chk("part_idle", busy, 0);
    chk("part_stop", stop_cnt - s0, 1);
    chk("part_ptr", reg_addr, 16'h0005);

    // one-cycle SDA glitches while SCL is high
    s0 = stop_cnt;
    sda_m = 1'b0; @(negedge clk); sda_m = 1'b1;
    wq();
    chk("gl_no_start", busy, 0);
    i2c_start();
    wr_byte(8'hA0, a);
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; @(negedge clk); sda_m = 1'b0;
    wq();
    scl_m = 1'b0; wq();
    chk("gl_no_stop", stop_cnt - s0, 0);
    chk("gl_busy", busy, 1);
    i2c_stop();

    // reset while the slave is driving a read bit
    i2c_start();
    wr_byte(8'hA0, a);
    wr_byte(8'h40, a);
    i2c_start();
    wr_byte(8'hA1, a);
    i2c_bit(1'b1, r1);
    i2c_bit(1'b1, r2);
    chk("rr_bit7", r1, 1);
    chk("rr_bit6", r2, 0);
    chk("rr_driving", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("rr_async_rel", sda_oe, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    i2c_stop();
    w0 = wren_cnt;
    i2c_start();
    wr_byte(8'hA0, a); chk("rr_ack_dev", a, 1);
    wr_byte(8'h20, a); chk("rr_ack_addr", a, 1);
    wr_byte(8'h07, a); chk("rr_ack_data", a, 1);
    i2c_stop();
    chk("rr_nwr", wren_cnt - w0, 1);
    chk("rr_wr_addr", wr_a[w0[4:0]], 16'h0020);
    chk("rr_wr_data", wr_d[w0[4:0]], 8'h07);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
